// File: rtl/bankregister.sv
// 64 x 32-bit general-purpose register file: two combinational read ports, one synchronous write port.
// Optional write-through forwarding on the read ports is enabled by defining BANKREGISTER_BYPASS_EN.
module bankregister #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] RegLe1,
   input  logic [ADDR_W-1:0] RegLe2,
   input  logic [ADDR_W-1:0] RegEscr,
   input  logic              EscrReg,
   input  logic [DATA_W-1:0] datain,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   // Next-state: at most one register takes the write data per edge.
   always_comb begin
      regs_d = regs_q;
      if (EscrReg) begin
         regs_d[RegEscr] = datain;
      end else begin
         regs_d = regs_q;
      end
   end

   // Storage; reset clears every register without waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

`ifdef BANKREGISTER_BYPASS_EN
   logic fwd1_s;
   logic fwd2_s;

   assign fwd1_s = EscrReg && !reset && (RegLe1 == RegEscr);
   assign fwd2_s = EscrReg && !reset && (RegLe2 == RegEscr);

   // Read ports forward the pending write data when they address the write target.
   always_comb begin
      if (fwd1_s) begin
         data1 = datain;
      end else begin
         data1 = regs_q[RegLe1];
      end
      if (fwd2_s) begin
         data2 = datain;
      end else begin
         data2 = regs_q[RegLe2];
      end
   end
`else
   assign data1 = regs_q[RegLe1];
   assign data2 = regs_q[RegLe2];
`endif

endmodule

// File: tb/tb_bankregister.sv
// Directed, table-driven bench for bankregister plus hand sequences for read-during-write,
// mid-cycle asynchronous reset and a full-array sweep.
module tb_bankregister;

   logic        clk;
   logic        reset;
   logic [5:0]  RegLe1;
   logic [5:0]  RegLe2;
   logic [5:0]  RegEscr;
   logic        EscrReg;
   logic [31:0] datain;
   logic [31:0] data1;
   logic [31:0] data2;

   int n_vec;
   int n_err;

   bankregister #(.ADDR_W(6), .DATA_W(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .RegLe1  (RegLe1),
      .RegLe2  (RegLe2),
      .RegEscr (RegEscr),
      .EscrReg (EscrReg),
      .datain  (datain),
      .data1   (data1),
      .data2   (data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we;
      logic [5:0]  wa;
      logic [31:0] wd;
      logic [5:0]  ra1;
      logic [5:0]  ra2;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic we, input logic [5:0] wa,
                        input logic [31:0] wd, input logic [5:0] ra1, input logic [5:0] ra2);
      reset   = rst;
      EscrReg = we;
      RegEscr = wa;
      datain  = wd;
      RegLe1  = ra1;
      RegLe2  = ra2;
   endtask

   initial begin
      logic [31:0] e1;
      logic [31:0] e2;
      n_vec = 0;
      n_err = 0;
      drive(1'b1, 1'b0, 6'd0, 32'h0, 6'd0, 6'd1);

      //           rst   we    wa      wd             ra1     ra2     exp1           exp2
      vecs[0] = '{1'b1, 1'b1, 6'd0,  32'h0000_0005, 6'd0,  6'd1,  32'h0000_0000, 32'h0000_0000};
      vecs[1] = '{1'b1, 1'b0, 6'd9,  32'h1234_0000, 6'd63, 6'd62, 32'h0000_0000, 32'h0000_0000};
      vecs[2] = '{1'b0, 1'b1, 6'd0,  32'h0000_0001, 6'd0,  6'd1,  32'h0000_0001, 32'h0000_0000};
      vecs[3] = '{1'b0, 1'b0, 6'd0,  32'hFFFF_FFFF, 6'd0,  6'd1,  32'h0000_0001, 32'h0000_0000};
      vecs[4] = '{1'b0, 1'b1, 6'd63, 32'hDEAD_BEEF, 6'd63, 6'd1,  32'hDEAD_BEEF, 32'h0000_0000};
      vecs[5] = '{1'b0, 1'b1, 6'd1,  32'h1234_5678, 6'd63, 6'd1,  32'hDEAD_BEEF, 32'h1234_5678};
      vecs[6] = '{1'b0, 1'b0, 6'd1,  32'h0BAD_0BAD, 6'd63, 6'd63, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[7] = '{1'b0, 1'b1, 6'd5,  32'h0000_000A, 6'd5,  6'd0,  32'h0000_000A, 32'h0000_0001};
      vecs[8] = '{1'b0, 1'b0, 6'd5,  32'h0000_0000, 6'd1,  6'd0,  32'h1234_5678, 32'h0000_0001};

      // Table vectors: drive on the falling edge, check 1 time unit after the rising edge.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.data1", i), data1, vecs[i].exp1);
         chk($sformatf("vec%0d.data2", i), data2, vecs[i].exp2);
      end

      // Read during write to reg 5 (holds 0xA).
      @(negedge clk);
      drive(1'b0, 1'b1, 6'd5, 32'h0000_000B, 6'd5, 6'd63);
      #1;
`ifdef BANKREGISTER_BYPASS_EN
      chk("rdw_before_edge", data1, 32'h0000_000B);
`else
      chk("rdw_before_edge", data1, 32'h0000_000A);
`endif
      chk("rdw_other_port", data2, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      chk("rdw_after_edge", data1, 32'h0000_000B);

      // Load regs 0..3, then pulse reset between edges.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 6'(i), 32'hC0DE_0000 + 32'(i) + 32'd1, 6'd0, 6'd3);
         @(posedge clk);
      end
      #1;
      chk("preload_r0", data1, 32'hC0DE_0001);
      chk("preload_r3", data2, 32'hC0DE_0004);
      @(negedge clk);
      EscrReg = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_r0", data1, 32'h0000_0000);
      chk("async_rst_r3", data2, 32'h0000_0000);
      @(negedge clk);
      drive(1'b1, 1'b1, 6'd2, 32'h0000_0077, 6'd2, 6'd63);
      @(posedge clk);
      #1;
      chk("write_in_rst_r2", data1, 32'h0000_0000);
      @(negedge clk);
      drive(1'b0, 1'b0, 6'd2, 32'h0000_0077, 6'd2, 6'd1);
      #1;
      chk("after_rst_r2", data1, 32'h0000_0000);
      chk("after_rst_r1", data2, 32'h0000_0000);

      // Full sweep: reg[i] = i * 0x01010101, then read pairs (i, 63-i).
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 6'(i), 32'(i) * 32'h0101_0101, 6'd0, 6'd0);
         @(posedge clk);
      end
      @(negedge clk);
      EscrReg = 1'b0;
      for (int i = 0; i < 64; i++) begin
         RegLe1 = 6'(i);
         RegLe2 = 6'(63 - i);
         #1;
         e1 = 32'(i) * 32'h0101_0101;
         e2 = 32'(63 - i) * 32'h0101_0101;
         chk($sformatf("sweep%0d.data1", i), data1, e1);
         chk($sformatf("sweep%0d.data2", i), data2, e2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
